nibble_serial_add_seq: RTL and testbench
========================================

// Module: nibble_serial_add_seq
// PURPOSE
//   Upstream sequencer for the 4-bit pipelined full-adder stage.
//   - Accepts WIDTH-bit operands over a valid/ready handshake.
//   - Feeds the adder one nibble at a time, LS nibble first, chaining each nibble's carry-out into the next carry-in.
//   - Captures each nibble sum and returns the full WIDTH-bit result plus carry-out over a second valid/ready handshake.
// PARAMETERS
//   WIDTH    16  operand/result width; multiple of 4, >= 4; NIB = WIDTH/4
//   ADD_LAT  2   clk edges from add_a/add_b/add_cin presented to add_sum/add_cout valid; >= 1
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      reset, asynchronous, active-high
//   in_valid    in   1      op_a/op_b/op_cin valid
//   in_ready    out  1      sequencer can accept an operation
//   op_a        in   WIDTH  operand A
//   op_b        in   WIDTH  operand B
//   op_cin      in   1      carry-in to nibble 0
//   add_a       out  4      nibble of A to adder stage
//   add_b       out  4      nibble of B to adder stage
//   add_cin     out  1      carry-in to adder stage
//   add_sum     in   4      registered sum from adder stage
//   add_cout    in   1      registered carry-out from adder stage
//   out_valid   out  1      result/result_cout valid
//   out_ready   in   1      consumer accepts result
//   result      out  WIDTH  op_a + op_b + op_cin, low WIDTH bits
//   result_cout out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset, async: state=IDLE; operand, carry, result, nibble-index and wait-counter regs = 0.
//     While rst is high: in_ready=0, out_valid=0, add_a=add_b=0, add_cin=0, result=0, result_cout=0.
//   FSM states: IDLE, ISSUE, WAIT, DONE.
//   IDLE: in_ready=1. On in_valid&in_ready:
//     - latch op_a, op_b; carry reg <= op_cin
//     - idx <= 0; result <= 0
//     - go to ISSUE
//   ISSUE (1 cycle): drive add_a=A[4*idx+:4], add_b=B[4*idx+:4], add_cin=carry reg.
//     wcnt <= 1; go to WAIT.
//   WAIT (ADD_LAT cycles): add_a/add_b/add_cin held at ISSUE values; wcnt increments.
//     On the cycle where wcnt==ADD_LAT:
//     - result[4*idx+:4] <= add_sum; carry reg <= add_cout
//     - if idx==NIB-1: go to DONE
//     - else: idx++ and go to ISSUE
//   DONE: out_valid=1; result/result_cout (=carry reg) held stable while out_ready=0.
//     On out_ready: go to IDLE.
//   In IDLE and DONE: add_a=add_b=0, add_cin=0.
//   Latency and throughput:
//     - out_valid rises NIB*(1+ADD_LAT) edges after the accept edge (12 for defaults).
//     - in_ready=0 from the accept edge until the edge leaving DONE.
//     - No accept in the same cycle as the out handshake, so minimum 1 bubble between ops.
//   Width: result = (op_a+op_b+op_cin) mod 2^WIDTH; result_cout = bit WIDTH of the true sum.
//   add_sum/add_cout are sampled only on the capture cycle; adder outputs are don't-care at all other times.
//   Boundaries:
//     - in_valid while busy: ignored; operands not latched.
//     - out_ready high outside DONE: ignored.
//     - rst mid-operation: immediate abort to IDLE; partial result discarded; next accepted op is correct.
//       The adder stage receives the same rst.
//     - WIDTH==4: single ISSUE/WAIT pass.
// TESTING (bench models the adder stage with ADD_LAT=2; WIDTH=16 unless noted)
//   1. op_a=0x1234, op_b=0x4321, cin=0 -> result=0x5555, cout=0, out_valid exactly 12 edges after accept.
//   2. 0xFFFF + 0x0001, cin=0 -> result=0x0000, cout=1.
//      Check carry propagated through all 4 nibbles: add_cin=1 on nibbles 1..3.
//   3. 0xFFFF + 0xFFFF, cin=1 -> result=0xFFFF, cout=1.
//      Then 0x0000 + 0x0000, cin=0 -> result=0x0000, cout=0.
//   4. out_ready=0 for 5 cycles in DONE -> result/out_valid stable.
//      in_ready=0, and a new in_valid during this time is not accepted.
//      Raise out_ready -> IDLE next edge, then the new op is accepted.
//   5. Assert rst 5 cycles after accept of 0xABCD+0x1111 -> all outputs 0 and in_ready=0 during rst.
//      After release: 0x0F0F + 0x00F1, cin=0 -> result=0x1000, cout=0.
//   6. 1000 random ops with random in_valid/out_ready gaps, repeated at WIDTH=8/ADD_LAT=1 and WIDTH=32/ADD_LAT=3
//      -> every result/cout matches the golden sum; no op lost or duplicated.

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_seq
// Description : Sequences a WIDTH-bit add through an external 4-bit pipelined
//               adder one nibble at a time, LS nibble first, with the carry
//               chained between nibbles. Returns the result over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_seq #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_cout
);
    localparam int c_NIB = WIDTH / 4;
    localparam int c_IW  = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam int c_CW  = $clog2(ADD_LAT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [c_IW-1:0]  r_idx;
    logic [c_CW-1:0]  r_wcnt;
    logic             w_capture;
    logic             w_last;

    // The adder output is only trusted on the last WAIT cycle of each nibble.
    assign w_capture = (r_state == c_WAIT) && (r_wcnt == c_CW'(ADD_LAT));
    assign w_last    = (r_idx == c_IW'(c_NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid) w_next = c_ISSUE;
            c_ISSUE: w_next = c_WAIT;
            c_WAIT:  if (w_capture) w_next = w_last ? c_DONE : c_ISSUE;
            c_DONE:  if (out_ready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        case (r_state)
            c_IDLE:  in_ready = !rst;
            c_ISSUE, c_WAIT: begin
                add_a   = r_a[{r_idx, 2'b00} +: 4];
                add_b   = r_b[{r_idx, 2'b00} +: 4];
                add_cin = r_carry;
            end
            c_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_idx    <= '0;
            r_wcnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_carry  <= op_cin;
                        r_idx    <= '0;
                        r_result <= '0;
                    end
                end
                c_ISSUE: r_wcnt <= c_CW'(1);
                c_WAIT: begin
                    if (w_capture) begin
                        r_result[{r_idx, 2'b00} +: 4] <= add_sum;
                        r_carry                       <= add_cout;
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result      = r_result;
    assign result_cout = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_seq.sv
`default_nettype none
// Bench for nibble_serial_add_seq: directed cases on a 16-bit/latency-2 instance,
// then scoreboarded random traffic on 16/2, 8/1 and 32/3 instances in parallel.
module tb_nibble_serial_add_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed instance (WIDTH=16, ADD_LAT=2) ----------------
    logic        rst = 1'b1;
    logic        in_valid, in_ready, op_cin, add_cin, add_cout;
    logic        out_valid, out_ready, result_cout;
    logic [15:0] op_a, op_b, result;
    logic [3:0]  add_a, add_b, add_sum;
    logic [4:0]  pipe [2];
    logic [16:0] sb [$];
    logic        rst_r   = 1'b1;
    logic        rand_go = 1'b0;

    nibble_serial_add_seq #(.WIDTH(16), .ADD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_cout(result_cout)
    );

    // Two-stage registered 4-bit adder model
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe[0] <= '0;
            pipe[1] <= '0;
        end else begin
            pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
            pipe[1] <= pipe[0];
        end
    end
    assign add_sum  = pipe[1][3:0];
    assign add_cout = pipe[1][4];

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check_eq("accept_ready", in_ready, 1);
        sb.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic await_out(output int lat, output logic [3:0] cins);
        lat  = 0;
        cins = '0;
        while (!out_valid && lat < 200) begin
            if (lat % 3 == 0 && lat < 12) cins[lat / 3] = add_cin;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("out_valid_seen", out_valid, 1);
    endtask

    task automatic take_out(input string tag);
        logic [16:0] e;
        check_eq({tag, "_sb"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq({tag, "_sum"}, result, e[15:0]);
            check_eq({tag, "_cout"}, result_cout, e[16]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [3:0] cins;
        in_valid = 0; op_a = 0; op_b = 0; op_cin = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", {in_ready, out_valid, add_a, add_b, add_cin, result, result_cout}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_ready", in_ready, 1);
        check_eq("idle_valid", out_valid, 0);

        issue(16'h1234, 16'h4321, 1'b0);
        await_out(lat, cins);
        check_eq("t1_latency", lat, 12);
        check_eq("t1_cins", cins, 4'b0000);
        take_out("t1");

        issue(16'hFFFF, 16'h0001, 1'b0);
        await_out(lat, cins);
        check_eq("t2_cins", cins, 4'b1110);
        take_out("t2");

        issue(16'hFFFF, 16'hFFFF, 1'b1);
        await_out(lat, cins);
        check_eq("t3a_cins", cins, 4'b1111);
        take_out("t3a");
        issue(16'h0000, 16'h0000, 1'b0);
        await_out(lat, cins);
        take_out("t3b");

        // Back-pressure in DONE with a competing request that must wait
        issue(16'h1111, 16'h2222, 1'b0);
        await_out(lat, cins);
        op_a = 16'h5A5A; op_b = 16'h0101; op_cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("t4_hold_valid", out_valid, 1);
            check_eq("t4_hold_result", result, 16'h3333);
            check_eq("t4_hold_ready", in_ready, 0);
        end
        take_out("t4a");
        check_eq("t4_idle_ready", in_ready, 1);
        sb.push_back({1'b0, op_a} + {1'b0, op_b} + 17'(op_cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("t4_busy", in_ready, 0);
        await_out(lat, cins);
        take_out("t4b");

        // Abort mid-operation
        issue(16'hABCD, 16'h1111, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_outs", {in_ready, out_valid, add_a, add_b, add_cin, result, result_cout}, 0);
        sb.delete();
        @(negedge clk);
        check_eq("t5_rst_hold", {in_ready, out_valid, add_a, add_b, add_cin, result, result_cout}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        issue(16'h0F0F, 16'h00F1, 1'b0);
        await_out(lat, cins);
        take_out("t5");

        @(negedge clk);
        rst_r   = 1'b0;
        rand_go = 1'b1;
        wait (g_rand[0].done && g_rand[1].done && g_rand[2].done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- random traffic at three configurations ----------------
    for (genvar k = 0; k < 3; k++) begin : g_rand
        localparam int W     = (k == 0) ? 16 : (k == 1) ? 8 : 32;
        localparam int L     = (k == 0) ? 2 : (k == 1) ? 1 : 3;
        localparam int N_OPS = 1000;

        logic         r_in_valid = 1'b0, r_op_cin = 1'b0, r_out_ready = 1'b0;
        logic         r_in_ready, r_add_cin, r_add_cout, r_out_valid, r_result_cout;
        logic [W-1:0] r_op_a = '0, r_op_b = '0, r_result;
        logic [3:0]   r_add_a, r_add_b, r_add_sum;
        logic [4:0]   r_pipe [L];
        logic [W:0]   r_sb [$];
        logic         done = 1'b0;

        nibble_serial_add_seq #(.WIDTH(W), .ADD_LAT(L)) u_dut (
            .clk(clk), .rst(rst_r), .in_valid(r_in_valid), .in_ready(r_in_ready),
            .op_a(r_op_a), .op_b(r_op_b), .op_cin(r_op_cin),
            .add_a(r_add_a), .add_b(r_add_b), .add_cin(r_add_cin),
            .add_sum(r_add_sum), .add_cout(r_add_cout),
            .out_valid(r_out_valid), .out_ready(r_out_ready),
            .result(r_result), .result_cout(r_result_cout)
        );

        always_ff @(posedge clk or posedge rst_r) begin
            if (rst_r) begin
                for (int i = 0; i < L; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= {1'b0, r_add_a} + {1'b0, r_add_b} + {4'b0, r_add_cin};
                for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end
        assign r_add_sum  = r_pipe[L-1][3:0];
        assign r_add_cout = r_pipe[L-1][4];

        initial begin : producer
            logic [31:0] ra, rb;
            wait (rand_go);
            for (int n = 0; n < N_OPS; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
                ra = $urandom;
                rb = $urandom;
                if ($urandom_range(0, 7) == 0) ra = '1;
                if ($urandom_range(0, 7) == 0) rb = '1;
                r_op_a     = ra[W-1:0];
                r_op_b     = rb[W-1:0];
                r_op_cin   = 1'($urandom_range(0, 1));
                r_in_valid = 1'b1;
                for (int t = 0; t < 1000 && !r_in_ready; t++) @(negedge clk);
                if (r_in_ready)
                    r_sb.push_back({1'b0, r_op_a} + {1'b0, r_op_b} + {{W{1'b0}}, r_op_cin});
                @(negedge clk);
                r_in_valid = 1'b0;
            end
        end

        initial begin : consumer
            int         got = 0;
            int         cyc = 0;
            logic [W:0] e;
            wait (rand_go);
            while (got < N_OPS && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                r_out_ready = ($urandom_range(0, 3) != 0);
                if (r_out_valid && r_out_ready) begin
                    check_eq($sformatf("w%0d_sb", W), r_sb.size() != 0, 1);
                    if (r_sb.size() != 0) begin
                        e = r_sb.pop_front();
                        check_eq($sformatf("w%0d_sum", W), r_result, e[W-1:0]);
                        check_eq($sformatf("w%0d_cout", W), r_result_cout, e[W]);
                    end
                    got++;
                end
            end
            r_out_ready = 1'b0;
            check_eq($sformatf("w%0d_count", W), got, N_OPS);
            check_eq($sformatf("w%0d_leftover", W), r_sb.size(), 0);
            done = 1'b1;
        end
    end

endmodule
`default_nettype wire
